// File: rtl/scan_seq_ctrl_pkg.sv
// scan_seq_pkg: state encoding, MISR polynomial and counter sizing shared by scan_seq_ctrl.
package scan_seq_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, FIN} state_e;
    localparam logic [15:0] MISR_POLY = 16'h1021;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/scan_seq_ctrl_if.sv
// scan_seq_ctrl_if: pattern-source beat stream (valid/ready plus stimulus, expected and mask bits).
interface scan_seq_ctrl_if;
    logic pat_valid;
    logic pat_ready;
    logic pat_tdi;
    logic pat_exp;
    logic pat_mask;
    modport master (output pat_valid, pat_tdi, pat_exp, pat_mask, input pat_ready);
    modport slave (input pat_valid, pat_tdi, pat_exp, pat_mask, output pat_ready);
endinterface

// File: rtl/scan_seq_ctrl_cmp_acc.sv
// scan_cmp_acc: per-beat sout compare, sticky fail, saturating fail count and optional
// CRC-16-CCITT serial MISR (enabled by SCAN_MISR_EN).
module scan_cmp_acc import scan_seq_pkg::*; #(
    parameter int PAT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             beat_i,
    input  logic             cmp_act_i,
    input  logic             sout_i,
    input  logic             pat_exp_i,
    input  logic             pat_mask_i,
    output logic             fail_o,
    output logic [PAT_W-1:0] fail_count_o
`ifdef SCAN_MISR_EN
    ,
    output logic [15:0]      signature_o
`endif
);
    logic step, mis;
    logic fail_q;
    logic [PAT_W-1:0] cnt_q;
    assign step = beat_i & cmp_act_i;
    assign mis = step & pat_mask_i & (sout_i ^ pat_exp_i);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fail_q <= 1'b0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            fail_q <= 1'b0;
            cnt_q  <= '0;
        end else if (mis) begin
            fail_q <= 1'b1;
            cnt_q  <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
    end
    assign fail_o = fail_q;
    assign fail_count_o = cnt_q;
`ifdef SCAN_MISR_EN
    // Signature folds every compared beat, masked or not.
    logic [15:0] sig_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sig_q <= '0;
        else if (clr_i) sig_q <= '0;
        else if (step) sig_q <= {sig_q[14:0], sig_q[15] ^ sout_i} ^ (sig_q[15] ? MISR_POLY : 16'h0);
    end
    assign signature_o = sig_q;
`endif
endmodule

// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: full-scan load/capture/unload sequencer; unload of pattern N overlaps load of N+1.
// Define SCAN_MISR_EN to add the 16-bit signature output.
module scan_seq_ctrl import scan_seq_pkg::*; #(
    parameter int CHAIN_LEN  = 21,
    parameter int PAT_W      = 16,
    parameter int CAP_CYCLES = 1
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic [PAT_W-1:0] num_patterns,
    scan_seq_ctrl_if.slave   pat,
    output logic             se,
    output logic             chain_ce,
    output logic             sin,
    input  logic             sout,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [PAT_W-1:0] fail_count,
    output logic [PAT_W-1:0] pat_idx
`ifdef SCAN_MISR_EN
    ,
    output logic [15:0]      signature
`endif
);
    localparam int BW = cnt_w(CHAIN_LEN);
    localparam int CW = cnt_w(CAP_CYCLES);
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] LAST_CAP = CW'(CAP_CYCLES - 1);
    state_e state_q, state_d;
    logic [BW-1:0] bit_q;
    logic [CW-1:0] cap_q;
    logic [PAT_W-1:0] num_q, idx_q;
    logic shift_q, busy_q, done_q;
    logic go, beat, last_bit, in_cap, last_cap, more, cmp_act;
    assign go = start & (state_q == IDLE);
    assign beat = shift_q & pat.pat_valid;
    assign last_bit = beat & (bit_q == LAST_BIT);
    assign in_cap = state_q == CAPTURE;
    assign last_cap = in_cap & (cap_q == LAST_CAP);
    // Extra bit keeps idx+1 from wrapping when num_patterns is all-ones.
    assign more = ({1'b0, idx_q} + {{PAT_W{1'b0}}, 1'b1}) < {1'b0, num_q};
    assign cmp_act = (state_q == UNLOAD) | ((state_q == LOAD) & (idx_q != '0));
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_patterns == '0) ? FIN : LOAD;
            LOAD:    if (last_bit) state_d = CAPTURE;
            CAPTURE: if (last_cap) state_d = more ? LOAD : UNLOAD;
            UNLOAD:  if (last_bit) state_d = FIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bit_q   <= '0;
            cap_q   <= '0;
            num_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= (state_d == LOAD) | (state_d == UNLOAD);
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == FIN;
            bit_q   <= last_bit ? '0 : bit_q + BW'(beat);
            cap_q   <= (in_cap & ~last_cap) ? cap_q + 1'b1 : '0;
            if (go) begin
                num_q <= num_patterns;
                idx_q <= '0;
            end else if (last_cap) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end
    assign se = shift_q;
    assign pat.pat_ready = shift_q;
    assign chain_ce = beat | in_cap;
    assign sin = beat & (state_q == LOAD) & pat.pat_tdi;
    assign busy = busy_q;
    assign done = done_q;
    assign pat_idx = idx_q;
    scan_cmp_acc #(.PAT_W(PAT_W)) u_cmp (
        .clk_i        (CK),
        .rst_i        (RST),
        .clr_i        (go),
        .beat_i       (beat),
        .cmp_act_i    (cmp_act),
        .sout_i       (sout),
        .pat_exp_i    (pat.pat_exp),
        .pat_mask_i   (pat.pat_mask),
        .fail_o       (fail),
        .fail_count_o (fail_count)
`ifdef SCAN_MISR_EN
        ,
        .signature_o  (signature)
`endif
    );
endmodule
